// File: rtl/joy_spinner_pkg.sv
// Shared types and helpers for the joystick-to-spinner emulator.
// Dial codes are active low; quadrature phase follows a 2-bit gray sequence.
package joy_spinner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } spin_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } spin_dir_t;

    localparam logic [1:0] DIAL_IDLE = 2'b11;
    localparam logic [1:0] DIAL_UP   = 2'b10;
    localparam logic [1:0] DIAL_DOWN = 2'b01;

    // UP walks 00->01->11->10, DOWN walks the reverse.
    function automatic logic [1:0] gray_next(input logic [1:0] phase, input spin_dir_t dir);
        logic [1:0] nxt;
        nxt = phase;
        if (dir == UP) begin
            case (phase)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else if (dir == DOWN) begin
            case (phase)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/joy_spinner_chan.sv
// One spinner channel: step FSM, tick counter, quadrature phase and wrapping step counter.
// All outputs are registered from the next-state values computed below.
module joy_spinner_chan
    import joy_spinner_pkg::*;
#(
    parameter int PER_W = 8,
    parameter int POS_W = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             enable,
    input  logic             mode,
    input  logic             invert,
    input  logic             dir_up,
    input  logic             dir_down,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] pulse_len,
    output logic [1:0]       dial,
    output logic [POS_W-1:0] step_cnt,
    output logic             busy
);

    spin_state_t      state_q, state_n;
    spin_dir_t        dir_q, dir_n, dir_in;
    logic [PER_W-1:0] cnt_q, cnt_n;
    logic [1:0]       phase_q, phase_n;
    logic [POS_W-1:0] step_n;
    logic [1:0]       dial_n;
    logic             mode_q;
    logic             restep;
    logic [PER_W-1:0] per_eff, plen_raw, plen_eff, per_last, plen_last;

    always_comb begin
        dir_in = NONE;
        if (dir_up && !dir_down)
            dir_in = invert ? DOWN : UP;
        else if (dir_down && !dir_up)
            dir_in = invert ? UP : DOWN;
    end

    // Zero lengths mean one tick; the pulse never outlasts the step period.
    always_comb begin
        per_eff   = (period == '0) ? PER_W'(1) : period;
        plen_raw  = (pulse_len == '0) ? PER_W'(1) : pulse_len;
        plen_eff  = mode ? PER_W'(1) : ((plen_raw > per_eff) ? per_eff : plen_raw);
        per_last  = per_eff - PER_W'(1);
        plen_last = plen_eff - PER_W'(1);
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        phase_n = phase_q;
        step_n  = step_cnt;
        restep  = 1'b0;

        if (!enable || (mode != mode_q)) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (ce) begin
            case (state_q)
                IDLE:  restep = 1'b1;
                PULSE: begin
                    if (cnt_q == per_last) begin
                        restep = 1'b1;
                    end else begin
                        cnt_n = cnt_q + PER_W'(1);
                        if (cnt_q == plen_last)
                            state_n = GAP;
                    end
                end
                GAP: begin
                    if (cnt_q == per_last)
                        restep = 1'b1;
                    else
                        cnt_n = cnt_q + PER_W'(1);
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase

            if (restep) begin
                cnt_n = '0;
                if (dir_in != NONE) begin
                    state_n = PULSE;
                    dir_n   = dir_in;
                    step_n  = (dir_in == UP) ? step_cnt + POS_W'(1) : step_cnt - POS_W'(1);
                    if (mode)
                        phase_n = gray_next(phase_q, dir_in);
                end else begin
                    state_n = IDLE;
                end
            end
        end

        if (mode)
            dial_n = phase_n;
        else if (state_n == PULSE)
            dial_n = (dir_n == UP) ? DIAL_UP : DIAL_DOWN;
        else
            dial_n = DIAL_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        mode_q <= mode;
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_q    <= NONE;
            phase_q  <= 2'b00;
            step_cnt <= '0;
            dial     <= mode ? 2'b00 : DIAL_IDLE;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            dir_q    <= dir_n;
            phase_q  <= phase_n;
            step_cnt <= step_n;
            dial     <= dial_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: rtl/joy_spinner_emu.sv
// Rate-controlled joystick-to-spinner converter for CHANNELS players.
// Each player gets an independent generator; outputs are packed per channel.
module joy_spinner_emu
    import joy_spinner_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PER_W    = 8,
    parameter int POS_W    = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       invert,
    input  logic [CHANNELS-1:0]       dir_up,
    input  logic [CHANNELS-1:0]       dir_down,
    input  logic [PER_W-1:0]          period,
    input  logic [PER_W-1:0]          pulse_len,
    output logic [2*CHANNELS-1:0]     dial_out,
    output logic [POS_W*CHANNELS-1:0] step_cnt,
    output logic [CHANNELS-1:0]       busy
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        joy_spinner_chan #(
            .PER_W (PER_W),
            .POS_W (POS_W)
        ) u_chan (
            .clk_sys   (clk_sys),
            .reset_n   (reset_n),
            .ce        (ce),
            .enable    (enable[c]),
            .mode      (mode),
            .invert    (invert[c]),
            .dir_up    (dir_up[c]),
            .dir_down  (dir_down[c]),
            .period    (period),
            .pulse_len (pulse_len),
            .dial      (dial_out[2*c +: 2]),
            .step_cnt  (step_cnt[POS_W*c +: POS_W]),
            .busy      (busy[c])
        );
    end

endmodule

// File: tb/tb_joy_spinner_emu.sv
// Scoreboard bench for joy_spinner_emu: directed scenarios followed by randomized segments.
module tb_joy_spinner_emu;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [1:0]  enable;
    logic        mode;
    logic [1:0]  invert;
    logic [1:0]  dir_up;
    logic [1:0]  dir_down;
    logic [7:0]  period;
    logic [7:0]  pulse_len;
    logic [3:0]  dial_out;
    logic [15:0] step_cnt;
    logic [1:0]  busy;

    joy_spinner_emu #(.CHANNELS(2), .PER_W(8), .POS_W(8)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce        (ce),
        .enable    (enable),
        .mode      (mode),
        .invert    (invert),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .period    (period),
        .pulse_len (pulse_len),
        .dial_out  (dial_out),
        .step_cnt  (step_cnt),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [3:0]  dial;
        logic [15:0] step;
        logic [1:0]  busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Behavioural model: a channel is "active" after a step and measures its age in ce ticks.
    bit         m_active[2];
    int         m_age[2];
    int         m_step[2];
    int         m_phase[2];
    int         m_ldir[2];
    logic       m_mode_prev;
    logic [1:0] gray_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_push();
        exp_t e;
        int   p, l, d;
        p = (period == 0) ? 1 : int'(period);
        l = (pulse_len == 0) ? 1 : int'(pulse_len);
        if (l > p) l = p;
        for (int c = 0; c < 2; c++) begin
            if (!reset_n) begin
                m_active[c] = 0; m_age[c] = 0; m_step[c] = 0; m_phase[c] = 0; m_ldir[c] = 0;
            end else if (!enable[c] || mode != m_mode_prev) begin
                m_active[c] = 0; m_age[c] = 0;
            end else if (ce) begin
                if (!m_active[c] || m_age[c] == p - 1) begin
                    d = 0;
                    if (dir_up[c] && !dir_down[c]) d = 1;
                    else if (dir_down[c] && !dir_up[c]) d = -1;
                    if (invert[c]) d = -d;
                    m_age[c] = 0;
                    if (d != 0) begin
                        m_active[c] = 1;
                        m_ldir[c]   = d;
                        m_step[c]   = (m_step[c] + d + 256) % 256;
                        if (mode) m_phase[c] = (m_phase[c] + d + 4) % 4;
                    end else begin
                        m_active[c] = 0;
                    end
                end else begin
                    m_age[c]++;
                end
            end
        end
        m_mode_prev = mode;
        for (int c = 0; c < 2; c++) begin
            if (mode)
                e.dial[2*c +: 2] = gray_tab[m_phase[c]];
            else if (m_active[c] && m_age[c] < l)
                e.dial[2*c +: 2] = (m_ldir[c] > 0) ? 2'b10 : 2'b01;
            else
                e.dial[2*c +: 2] = 2'b11;
            e.step[8*c +: 8] = 8'(m_step[c]);
            e.busy[c]        = m_active[c];
        end
        exp_q.push_back(e);
    endtask

    // Inputs are held across the next rising edge and changed only after the falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_push();
            @(negedge clk_sys);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dial_out", {12'd0, dial_out}, {12'd0, e.dial});
                check("step_cnt", step_cnt, e.step);
                check("busy", {14'd0, busy}, {14'd0, e.busy});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [7:0] held;
        reset_n = 1'b0; ce = 1'b1; enable = 2'b11; mode = 1'b0; invert = 2'b00;
        dir_up = 2'b01; dir_down = 2'b00; period = 8'd4; pulse_len = 8'd2;
        m_mode_prev = 1'b0;
        @(negedge clk_sys);

        // Reset with up held
        tick(3);
        check("reset_dial", {12'd0, dial_out}, 16'h000F);

        // Mode 0, period 4, pulse 2, ch0 up held for 12 ticks
        reset_n = 1'b1;
        tick(12);
        check("hold_steps", {8'd0, step_cnt[7:0]}, 16'd3);
        check("ch1_idle", {14'd0, dial_out[3:2]}, 16'h0003);
        dir_up = 2'b00;
        tick(6);

        // Direction flip mid-pulse
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        dir_up = 2'b01; tick(1);
        dir_up = 2'b00; dir_down = 2'b01; tick(4);
        check("flip_dial", {14'd0, dial_out[1:0]}, 16'h0001);
        dir_down = 2'b00; tick(6);
        check("flip_return", {8'd0, step_cnt[7:0]}, 16'd0);

        // Mode 1, period 1, ch1 down for 5 ticks
        reset_n = 1'b0; mode = 1'b1; period = 8'd1; tick(2); reset_n = 1'b1;
        dir_down = 2'b10; tick(5);
        dir_down = 2'b00; tick(3);
        check("quad_step", {8'd0, step_cnt[15:8]}, 16'h00FB);
        check("quad_phase", {14'd0, dial_out[3:2]}, 16'h0002);

        // Enable drop mid-pulse
        mode = 1'b0; period = 8'd4; pulse_len = 8'd3; dir_up = 2'b01;
        tick(3);
        enable = 2'b10; tick(1);
        check("en_drop_dial", {14'd0, dial_out[1:0]}, 16'h0003);
        check("en_drop_busy", {15'd0, busy[0]}, 16'd0);
        check("en_drop_step", {8'd0, step_cnt[7:0]}, 16'd1);
        enable = 2'b11; dir_up = 2'b00; tick(2);

        // Both directions with sparse ce, then up alone
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        dir_up = 2'b01; dir_down = 2'b01;
        for (int i = 0; i < 8; i++) begin
            ce = (i % 4 == 3);
            tick(1);
        end
        check("both_nostep", {8'd0, step_cnt[7:0]}, 16'd0);
        dir_down = 2'b00; ce = 1'b0; tick(2);
        check("wait_ce_busy", {15'd0, busy[0]}, 16'd0);
        ce = 1'b1; tick(1);
        check("first_step", {8'd0, step_cnt[7:0]}, 16'd1);
        ce = 1'b0; tick(1);

        // Randomized segments; timing parameters only change under reset
        for (int s = 0; s < 8; s++) begin
            reset_n   = 1'b0;
            mode      = 1'($urandom_range(0, 1));
            period    = 8'($urandom_range(0, 5));
            pulse_len = 8'($urandom_range(0, 6));
            invert    = 2'($urandom_range(0, 3));
            tick(2);
            reset_n = 1'b1;
            held = step_cnt[7:0];
            for (int i = 0; i < 300; i++) begin
                ce = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 2; c++) begin
                    enable[c] = ($urandom_range(0, 15) != 0);
                    if ($urandom_range(0, 3) == 0) dir_up[c] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) dir_down[c] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 63) == 0) mode = ~mode;
                tick(1);
            end
        end
        enable = 2'b11;

        repeat (3) @(negedge clk_sys);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
